dffram_wb_adapter: RTL and testbench
====================================

// Module: dffram_wb_adapter
// PURPOSE
//  Wishbone B4 classic slave front-end that sits directly upstream of a DFFRAM
//  macro (CLK/EN0/WE0[3:0]/A0/Di0/Do0 port set) and drives it.
//  Decodes the bus address, converts byte selects into per-byte write enables,
//  and sequences the RAM's one-cycle read latency into a registered read ack.
//  One outstanding transaction at a time.
// PARAMETERS
//  AW         8             RAM word-address width (256 words)
//  BASE_ADDR  32'h3000_0000 byte base address of the RAM window
//  ADDR_MASK  32'hFFFF_FC00 decode mask; hit = (wb_adr_i & ADDR_MASK) == BASE_ADDR
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  RST        in   1   synchronous reset, active-high
//  wb_cyc_i   in   1   bus cycle valid
//  wb_stb_i   in   1   strobe; request = wb_cyc_i & wb_stb_i & hit
//  wb_we_i    in   1   1 = write, 0 = read
//  wb_sel_i   in   4   byte selects; bit n covers data[8n+7:8n]
//  wb_adr_i   in   32  byte address; word index = wb_adr_i[AW+1:2]
//  wb_dat_i   in   32  write data
//  wb_dat_o   out  32  read data, registered
//  wb_ack_o   out  1   one-cycle transfer acknowledge, registered
//  ram_en0    out  1   RAM enable (RAM samples A0/WE0/Di0 on rising CLK when 1)
//  ram_we0    out  4   RAM byte write enables
//  ram_a0     out  AW  RAM word address
//  ram_di0    out  32  RAM write data
//  ram_do0    in   32  RAM read data, valid the cycle after an enabled read edge
// BEHAVIOUR
//  - Reset (RST=1 at an edge): state=IDLE, wb_ack_o=0, wb_dat_o=0. ram_en0 and
//    ram_we0 are forced to 0 while RST=1.
//  - FSM states: IDLE, WACK, RWAIT, RACK.
//  - RAM-side outputs are combinational from the bus inputs:
//    ram_a0 = wb_adr_i[AW+1:2]; ram_di0 = wb_dat_i;
//    ram_en0 = (state==IDLE) & request & ~RST;
//    ram_we0 = ram_en0 & wb_we_i ? wb_sel_i : 4'b0.
//  - IDLE: if request & wb_we_i -> WACK. If request & ~wb_we_i -> RWAIT.
//    Otherwise stay in IDLE. A miss (no hit) is never acked; another slave owns it.
//  - WACK: wb_ack_o=1 for exactly this cycle. Write was committed at entry edge.
//    Next state is IDLE. Write latency is 1 cycle (request edge to ack).
//  - RWAIT: the RAM has captured the address. At the next edge,
//    wb_dat_o <= ram_do0 and state -> RACK. If wb_cyc_i=0 in RWAIT (abort),
//    state -> IDLE, no ack, wb_dat_o is unchanged.
//  - RACK: wb_ack_o=1 for exactly this cycle and wb_dat_o is stable. Next state
//    is IDLE. Read latency is 2 cycles.
//  - The FSM accepts no request in WACK, RWAIT or RACK. stb held through the
//    ack cycle is therefore never double-counted. A new request is taken in the
//    first IDLE cycle, so the peak rate is one write per 2 cycles and one read
//    per 3 cycles.
//  - wb_sel_i=0 on a write: ram_en0=1 and ram_we0=0 (no memory change), and the
//    ack is issued normally.
//  - A partial sel on a write updates only the selected bytes. Reads ignore sel
//    and return the full word.
//  - Address wrap: only bits [AW+1:2] index the RAM. Bits [1:0] are ignored.
//  - RST asserted mid-transaction: the transaction is dropped with no ack. A
//    write whose enable edge already occurred stays committed.
//  - wb_ack_o is never 1 in two consecutive cycles.
// TESTING
//  1 Reset: hold RST 2 cycles with request active -> ram_en0=0, ack=0, dat_o=0.
//  2 Write 0x3000_0010 = 0xDEADBEEF, sel=F -> ram_en0=1, we0=F, a0=0x04;
//    ack 1 cycle later; readback of 0x3000_0010 gives 0xDEADBEEF, ack 2 cycles
//    after the request.
//  3 Byte write to 0x3000_0010, sel=4'b0010, dat=0x0000_5500 -> readback is
//    0xDEAD55EF. A sel=0 write leaves the word unchanged and is still acked.
//  4 Back-to-back reads of 0x3000_0000 and 0x3000_03FC with stb held -> two
//    single-cycle acks 3 cycles apart, correct data. Word 0xFF addresses the
//    top entry.
//  5 Miss at 0x3000_0400 held 10 cycles -> ram_en0 stays 0, no ack.
//    Drop cyc in RWAIT -> no ack, FSM back in IDLE, next request serviced.
//  6 Random mixed traffic vs reference memory model -> data matches; every
//    hit acked exactly once; ack never high 2 cycles in a row.

Source files
------------

// File: rtl/dffram_wb_adapter.sv
// rtl/dffram_wb_adapter.sv - Wishbone B4 classic slave front-end driving a DFFRAM macro
// One transaction at a time; writes ack after 1 cycle, reads after 2 (RAM read latency).
module dffram_wb_adapter #(
   parameter int          AW        = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [3:0]    wb_sel_i,
   input  logic [31:0]   wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          ram_en0,
   output logic [3:0]    ram_we0,
   output logic [AW-1:0] ram_a0,
   output logic [31:0]   ram_di0,
   input  logic [31:0]   ram_do0
);

   typedef enum logic [1:0] {IDLE, WACK, RWAIT, RACK} state_t;

   state_t state;
   state_t state_nxt;
   logic   hit;
   logic   req;

   assign hit     = (wb_adr_i & ADDR_MASK) == BASE_ADDR;
   assign req     = wb_cyc_i & wb_stb_i & hit;
   assign ram_a0  = wb_adr_i[AW+1:2];
   assign ram_di0 = wb_dat_i;

   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = wb_we_i ? WACK : RWAIT;
         WACK:    state_nxt = IDLE;
         // dropping cyc while the RAM is still reading abandons the read silently
         RWAIT:   state_nxt = wb_cyc_i ? RACK : IDLE;
         RACK:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Requests are only issued to the RAM from IDLE, so a held stb is never taken twice.
   always_comb begin
      ram_en0 = (state == IDLE) & req & ~RST;
      ram_we0 = (ram_en0 & wb_we_i) ? wb_sel_i : 4'b0000;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'h0000_0000;
      end else begin
         wb_ack_o <= (state_nxt == WACK) || (state_nxt == RACK);
         if (state == RWAIT && wb_cyc_i)
            wb_dat_o <= ram_do0;
      end
   end

endmodule

// File: tb/tb_dffram_wb_adapter.sv
// tb/tb_dffram_wb_adapter.sv - directed and random checks of dffram_wb_adapter against a reference memory
module tb_dffram_wb_adapter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic        wb_ack_o;
   logic        ram_en0;
   logic [3:0]  ram_we0;
   logic [7:0]  ram_a0;
   logic [31:0] ram_di0, ram_do0;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_acks = 0;
   int ack_total = 0;
   int ack_double = 0;
   logic prev_ack = 1'b0;
   logic [31:0] ram_mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] last_rd;

   always #5 CLK = ~CLK;

   dffram_wb_adapter dut (
      .CLK(CLK), .RST(RST),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .ram_en0(ram_en0), .ram_we0(ram_we0), .ram_a0(ram_a0),
      .ram_di0(ram_di0), .ram_do0(ram_do0)
   );

   // DFFRAM behaviour: byte-enabled write, registered read of the old word
   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      ram_do0 = 32'h0;
   end

   always @(posedge CLK) begin
      if (ram_en0) begin
         for (int b = 0; b < 4; b++)
            if (ram_we0[b]) ram_mem[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
         ram_do0 <= ram_mem[ram_a0];
      end
   end

   always @(negedge CLK) begin
      if (wb_ack_o) ack_total <= ack_total + 1;
      if (wb_ack_o && prev_ack) ack_double <= ack_double + 1;
      prev_ack <= wb_ack_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic bus_idle();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_sel_i = 4'h0; wb_adr_i = 32'h0; wb_dat_i = 32'h0;
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(posedge CLK); #1;
         n++;
      end while (!wb_ack_o && n < 8);
   endtask

   // called at posedge+1; leaves at posedge+1 of the first IDLE cycle after the ack
   task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
      int n;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      #1;
      check({tag, "_en"}, {31'b0, ram_en0}, 32'd1);
      check({tag, "_we"}, {28'b0, ram_we0}, {28'b0, sel});
      check({tag, "_a0"}, {24'b0, ram_a0}, {24'b0, adr[9:2]});
      wait_ack(n);
      check({tag, "_wlat"}, n, 32'd1);
      bus_idle();
      @(posedge CLK); #1;
      check({tag, "_ackdrop"}, {31'b0, wb_ack_o}, 32'd0);
      ref_mem[adr[9:2]] = merge(ref_mem[adr[9:2]], dat, sel);
      exp_acks++;
   endtask

   task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      int n;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = adr; wb_sel_i = 4'($urandom_range(0, 15));
      #1;
      check({tag, "_ren"}, {31'b0, ram_en0}, 32'd1);
      check({tag, "_rwe"}, {28'b0, ram_we0}, 32'd0);
      wait_ack(n);
      check({tag, "_rlat"}, n, 32'd2);
      check({tag, "_rdat"}, wb_dat_o, exp);
      bus_idle();
      @(posedge CLK); #1;
      check({tag, "_ackdrop"}, {31'b0, wb_ack_o}, 32'd0);
      last_rd = exp;
      exp_acks++;
   endtask

   initial begin
      int n;
      int seen_en, seen_ack;
      logic [31:0] a, d;
      logic [3:0]  s;

      // reset with a hit write request held active
      RST = 1'b1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_sel_i = 4'hF; wb_adr_i = 32'h3000_0020; wb_dat_i = 32'h1234_5678;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_en", {31'b0, ram_en0}, 32'd0);
      check("rst_we", {28'b0, ram_we0}, 32'd0);
      check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
      check("rst_dat", wb_dat_o, 32'd0);
      bus_idle();
      RST = 1'b0;
      @(posedge CLK); #1;
      check("rst_nowrite", ram_mem[8], 32'd0);

      // full word write and readback
      wb_write("w_full", 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
      wb_read ("r_full", 32'h3000_0010, 32'hDEAD_BEEF);

      // byte write, then a sel=0 write that must not change the word
      wb_write("w_byte", 32'h3000_0010, 32'h0000_5500, 4'b0010);
      wb_read ("r_byte", 32'h3000_0010, 32'hDEAD_55EF);
      wb_write("w_sel0", 32'h3000_0010, 32'hFFFF_FFFF, 4'b0000);
      wb_read ("r_sel0", 32'h3000_0010, 32'hDEAD_55EF);

      // back-to-back reads of word 0 and the top word with stb held
      wb_write("w_w0",   32'h3000_0000, 32'hA5A5_0001, 4'hF);
      wb_write("w_wtop", 32'h3000_03FC, 32'h5A5A_00FF, 4'hF);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h3000_0000;
      wait_ack(n);
      check("b2b_lat0", n, 32'd2);
      check("b2b_dat0", wb_dat_o, 32'hA5A5_0001);
      wb_adr_i = 32'h3000_03FC;
      wait_ack(n);
      check("b2b_gap", n, 32'd3);
      check("b2b_dattop", wb_dat_o, 32'h5A5A_00FF);
      bus_idle();
      @(posedge CLK); #1;
      check("b2b_ackdrop", {31'b0, wb_ack_o}, 32'd0);
      exp_acks += 2;
      last_rd = 32'h5A5A_00FF;

      // address bits [1:0] and bits above the word index inside the window are ignored
      wb_read("r_wrap", 32'h3000_03FF, 32'h5A5A_00FF);

      // miss held for 10 cycles
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_sel_i = 4'hF; wb_adr_i = 32'h3000_0400; wb_dat_i = 32'hBAD0_BAD0;
      seen_en = 0; seen_ack = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (ram_en0) seen_en++;
         if (wb_ack_o) seen_ack++;
      end
      check("miss_en", seen_en, 32'd0);
      check("miss_ack", seen_ack, 32'd0);
      check("miss_nowrite", ram_mem[0], 32'hA5A5_0001);
      bus_idle();
      @(posedge CLK); #1;

      // read aborted in RWAIT
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h3000_0000;
      @(posedge CLK); #1;
      bus_idle();
      seen_ack = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (wb_ack_o) seen_ack++;
      end
      check("abort_ack", seen_ack, 32'd0);
      check("abort_dat", wb_dat_o, last_rd);
      @(posedge CLK); #1;
      wb_read("r_after_abort", 32'h3000_0000, 32'hA5A5_0001);

      // random mixed traffic against the reference memory
      for (int i = 0; i < 60; i++) begin
         a = 32'h3000_0000 | {22'b0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            wb_write("rnd_w", a, d, s);
         end else begin
            wb_read("rnd_r", a, ref_mem[a[9:2]]);
         end
      end

      @(posedge CLK); #1;
      check("ack_count", ack_total, exp_acks);
      check("ack_double", ack_double, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
